perf_monitor_mc: RTL
====================

PERF_MONITOR_MC -- requirements
Module: perf_monitor_mc

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of monitored valid/ready channels; legal range 1..8.
REQ-002 Parameter CNT_WIDTH, default 32, meaning width of every event counter; legal range 8..32.
REQ-003 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_ni  input  1  asynchronous active-low reset.
REQ-005 Port reg_valid_i  input  1  register access request.
REQ-006 Port reg_write_i  input  1  1 = write, 0 = read.
REQ-007 Port reg_addr_i  input  8  byte address; bits [1:0] ignored.
REQ-008 Port reg_wdata_i  input  32  write data.
REQ-009 Port reg_ready_o  output  1  access accepted; tied 1.
REQ-010 Port reg_rvalid_o  output  1  read data valid.
REQ-011 Port reg_rdata_o  output  32  read data, zero-extended from CNT_WIDTH.
REQ-012 Port reg_err_o  output  1  unmapped access, valid with reg_rvalid_o.
REQ-013 Port mon_valid_i  input  NUM_CH  per-channel probed valid.
REQ-014 Port mon_ready_i  input  NUM_CH  per-channel probed ready.
REQ-015 Port irq_o  output  1  threshold interrupt (present only under PERF_MON_IRQ_EN).

Function
REQ-016 Register map: 0x00 CTRL, 0x04 STATUS, 0x08 CYCLE; channel c at 0x10+0x10*c: +0x0 XFER, +0x4 STALL, +0x8 IDLE, +0xC THRESH.
REQ-017 CTRL bit0 EN (R/W); bit1 CLR (write-1 pulse, reads 0); bit2 IRQ_EN (R/W, reads 0 without macro).
REQ-018 While EN=1, CYCLE increments every cycle.
REQ-019 While EN=1, per channel: XFER += valid&ready; STALL += valid&!ready; IDLE += !valid&ready; none counted for !valid&!ready.
REQ-020 Counters update the cycle after the sampled event (one-cycle latency from probe to register value).
REQ-021 Counters wrap modulo 2^CNT_WIDTH; on wrap, sticky STATUS bit set: bit 3*c+k (k=0 XFER,1 STALL,2 IDLE), bit 31 CYCLE.
REQ-022 STATUS bits cleared by writing 1 to the bit (W1C); set and W1C in same cycle: set wins.
REQ-023 CLR zeroes all counters and STATUS in the cycle after the write; CLR beats a same-cycle increment; EN and THRESH unaffected.
REQ-024 Write with EN=0 freezes counters; values held, readable.
REQ-025 Writes to CYCLE/XFER/STALL/IDLE ignored, no error.
REQ-026 Read: reg_rvalid_o high exactly one cycle after accepted read, rdata holds value sampled at acceptance cycle.
REQ-027 Writes produce no rvalid response; back-to-back accesses every cycle supported.
REQ-028 Unmapped address (incl. channel slots >= NUM_CH): read returns 0 with reg_err_o=1; write ignored, no response.

Reset
REQ-029 On rst_ni low, immediately: all counters, STATUS, CTRL, THRESH = 0; reg_rvalid_o=0, reg_rdata_o=0, reg_err_o=0, irq_o=0.
REQ-030 Reset mid-read discards the pending response; first access after deassertion behaves as from idle.

Configuration
REQ-031 Macro PERF_MON_IRQ_EN defined: irq_o registered, high while IRQ_EN=1 and any channel's XFER >= nonzero THRESH; THRESH=0 disables that channel.
REQ-032 Macro undefined: irq_o port, THRESH storage and IRQ_EN absent; THRESH reads 0 without error, writes ignored.

Structure
REQ-033 Package perf_monitor_pkg holds register offset constants, CTRL bit indices, and the per-channel counter struct typedef.
REQ-034 Sub-module perf_counter_ch: one channel's three counters, overflow flags and threshold compare; instantiated NUM_CH times via generate.

Verification
REQ-035 EN=1, ch0 valid=1 ready=1 for 10 cycles, then EN=0 -> XFER0=10, STALL0=0, IDLE0=0, CYCLE>=10.
REQ-036 ch1 valid=1 ready=0 for 5 cycles, then ready=1 for 3 -> STALL1=5, XFER1=3.
REQ-037 CNT_WIDTH=8, 256 transfers on ch2 -> XFER2=0, STATUS bit 6 set; W1C 0x40 -> STATUS=0.
REQ-038 CLR written in same cycle as a transfer on ch0 -> XFER0 reads 0 next cycle.
REQ-039 Macro on, THRESH0=4, IRQ_EN=1, 4 transfers -> irq_o rises the cycle after XFER0 reaches 4; CLR -> irq_o low.
REQ-040 Read 0x90 with NUM_CH=4 -> rvalid one cycle later, rdata=0, err=1; assert rst_ni mid-read -> no rvalid.

Source files
------------

// File: rtl/perf_monitor_mc_pkg.sv
// Shared definitions for the multi-channel performance monitor: register
// offsets, CTRL bit positions, per-channel counter bundle and address decode.
package perf_monitor_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CYCLE  = 8'h08;
  localparam logic [7:0] CH_BASE     = 8'h10;

  localparam logic [3:0] OFS_XFER   = 4'h0;
  localparam logic [3:0] OFS_STALL  = 4'h4;
  localparam logic [3:0] OFS_IDLE   = 4'h8;
  localparam logic [3:0] OFS_THRESH = 4'hC;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_CLR         = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned STATUS_CYCLE_BIT = 31;

  // Counter values zero-extended to the bus width so the read mux is uniform.
  typedef struct packed {
    logic [31:0] xfer;
    logic [31:0] stall;
    logic [31:0] idle;
  } perf_ch_cnt_t;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_XFER,
    SEL_STALL,
    SEL_IDLE,
    SEL_THRESH,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_sel(input logic [7:0] addr, input int unsigned num_ch);
    logic [7:0] word;
    logic [3:0] slot;
    word = {addr[7:2], 2'b00};
    slot = addr[7:4];
    decode_sel = SEL_NONE;
    if (word == ADDR_CTRL) begin
      decode_sel = SEL_CTRL;
    end else if (word == ADDR_STATUS) begin
      decode_sel = SEL_STATUS;
    end else if (word == ADDR_CYCLE) begin
      decode_sel = SEL_CYCLE;
    end else if (word >= CH_BASE && 32'(slot) <= num_ch) begin
      case (word[3:0])
        OFS_XFER:   decode_sel = SEL_XFER;
        OFS_STALL:  decode_sel = SEL_STALL;
        OFS_IDLE:   decode_sel = SEL_IDLE;
        OFS_THRESH: decode_sel = SEL_THRESH;
        default:    decode_sel = SEL_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/perf_counter_ch.sv
// One monitored channel: transfer/stall/idle counters with wrap flags and,
// under PERF_MON_IRQ_EN, the threshold compare against the transfer count.
module perf_counter_ch
  import perf_monitor_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
`ifdef PERF_MON_IRQ_EN
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic                 thr_hit_o,
`endif
  output perf_ch_cnt_t         cnt_o,
  output logic [2:0]           ovf_o
);

  logic [CNT_WIDTH-1:0] xfer_q, stall_q, idle_q;
  logic inc_xfer, inc_stall, inc_idle;

  assign inc_xfer  = en_i &  valid_i &  ready_i;
  assign inc_stall = en_i &  valid_i & ~ready_i;
  assign inc_idle  = en_i & ~valid_i &  ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xfer_q  <= '0;
      stall_q <= '0;
      idle_q  <= '0;
    end else if (clr_i) begin
      xfer_q  <= '0;
      stall_q <= '0;
      idle_q  <= '0;
    end else begin
      if (inc_xfer)  xfer_q  <= xfer_q  + CNT_WIDTH'(1);
      if (inc_stall) stall_q <= stall_q + CNT_WIDTH'(1);
      if (inc_idle)  idle_q  <= idle_q  + CNT_WIDTH'(1);
    end
  end

  // A flag pulses on the increment that takes a counter from all-ones to zero.
  assign ovf_o[0] = inc_xfer  & (&xfer_q);
  assign ovf_o[1] = inc_stall & (&stall_q);
  assign ovf_o[2] = inc_idle  & (&idle_q);

  assign cnt_o.xfer  = 32'(xfer_q);
  assign cnt_o.stall = 32'(stall_q);
  assign cnt_o.idle  = 32'(idle_q);

`ifdef PERF_MON_IRQ_EN
  assign thr_hit_o = (thresh_i != '0) && (xfer_q >= thresh_i);
`endif

endmodule

// File: rtl/perf_monitor_mc.sv
// Multi-channel valid/ready performance monitor with a register interface.
// Optional threshold interrupt is built only when PERF_MON_IRQ_EN is defined.
module perf_monitor_mc
  import perf_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reg_valid_i,
  input  logic              reg_write_i,
  input  logic [7:0]        reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic              reg_ready_o,
  output logic              reg_rvalid_o,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_err_o,
`ifdef PERF_MON_IRQ_EN
  output logic              irq_o,
`endif
  input  logic [NUM_CH-1:0] mon_valid_i,
  input  logic [NUM_CH-1:0] mon_ready_i
);

  reg_sel_e             sel;
  logic [3:0]           ch_idx;
  logic                 wr, rd, ctrl_wr, clr;
  logic                 en_q;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic                 cyc_ovf;
  logic [31:0]          status_q, status_set, status_w1c;
  logic [31:0]          rd_data;
  logic                 rd_err;
  logic                 addr_lsb_unused;
  perf_ch_cnt_t         ch_cnt [NUM_CH];
  logic [2:0]           ch_ovf [NUM_CH];
`ifdef PERF_MON_IRQ_EN
  logic                 irq_en_q;
  logic [CNT_WIDTH-1:0] thresh_q [NUM_CH];
  logic [NUM_CH-1:0]    thr_hit;
`endif

  assign reg_ready_o     = 1'b1;
  assign addr_lsb_unused = ^reg_addr_i[1:0];

  assign sel     = decode_sel(reg_addr_i, NUM_CH);
  assign ch_idx  = reg_addr_i[7:4] - 4'd1;
  assign wr      = reg_valid_i &  reg_write_i;
  assign rd      = reg_valid_i & ~reg_write_i;
  assign ctrl_wr = wr && (sel == SEL_CTRL);
  assign clr     = ctrl_wr & reg_wdata_i[CTRL_CLR];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter_ch #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_q),
      .clr_i    (clr),
      .valid_i  (mon_valid_i[g]),
      .ready_i  (mon_ready_i[g]),
`ifdef PERF_MON_IRQ_EN
      .thresh_i (thresh_q[g]),
      .thr_hit_o(thr_hit[g]),
`endif
      .cnt_o    (ch_cnt[g]),
      .ovf_o    (ch_ovf[g])
    );
  end

  assign cyc_ovf    = en_q & (&cycle_q);
  assign status_w1c = (wr && (sel == SEL_STATUS)) ? reg_wdata_i : '0;

  always_comb begin
    status_set = '0;
    status_set[STATUS_CYCLE_BIT] = cyc_ovf;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      status_set[3*c +: 3] = ch_ovf[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      cycle_q  <= '0;
      status_q <= '0;
    end else begin
      if (ctrl_wr) en_q <= reg_wdata_i[CTRL_EN];
      if (clr) begin
        cycle_q  <= '0;
        status_q <= '0;
      end else begin
        if (en_q) cycle_q <= cycle_q + CNT_WIDTH'(1);
        // Set is OR-ed after the W1C mask so a same-cycle wrap is never lost.
        status_q <= (status_q & ~status_w1c) | status_set;
      end
    end
  end

`ifdef PERF_MON_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) thresh_q[c] <= '0;
    end else begin
      if (ctrl_wr) irq_en_q <= reg_wdata_i[CTRL_IRQ_EN];
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr && (sel == SEL_THRESH) && (32'(ch_idx) == c)) begin
          thresh_q[c] <= reg_wdata_i[CNT_WIDTH-1:0];
        end
      end
      irq_o <= irq_en_q & (|thr_hit);
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (sel)
      SEL_CTRL: begin
        rd_data[CTRL_EN] = en_q;
`ifdef PERF_MON_IRQ_EN
        rd_data[CTRL_IRQ_EN] = irq_en_q;
`endif
      end
      SEL_STATUS: rd_data = status_q;
      SEL_CYCLE:  rd_data = 32'(cycle_q);
      SEL_XFER, SEL_STALL, SEL_IDLE, SEL_THRESH: begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (32'(ch_idx) == c) begin
            case (sel)
              SEL_XFER:  rd_data = ch_cnt[c].xfer;
              SEL_STALL: rd_data = ch_cnt[c].stall;
              SEL_IDLE:  rd_data = ch_cnt[c].idle;
`ifdef PERF_MON_IRQ_EN
              SEL_THRESH: rd_data = 32'(thresh_q[c]);
`endif
              default:   rd_data = '0;
            endcase
          end
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
      reg_err_o    <= 1'b0;
    end else if (rd) begin
      reg_rvalid_o <= 1'b1;
      reg_rdata_o  <= rd_data;
      reg_err_o    <= rd_err;
    end else begin
      reg_rvalid_o <= 1'b0;
      reg_err_o    <= 1'b0;
    end
  end

endmodule
